// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the multi-cycle processor control path: opcodes,
// ALU operations, datapath mux selects and the control FSM state set.
package proc_ctrl_pkg;

   localparam logic [3:0] OP_R    = 4'd0;
   localparam logic [3:0] OP_ADDI = 4'd1;
   localparam logic [3:0] OP_ANDI = 4'd2;
   localparam logic [3:0] OP_ORI  = 4'd3;
   localparam logic [3:0] OP_LW   = 4'd4;
   localparam logic [3:0] OP_SW   = 4'd5;
   localparam logic [3:0] OP_BEQ  = 4'd6;
   localparam logic [3:0] OP_BNE  = 4'd7;
   localparam logic [3:0] OP_BLT  = 4'd8;
   localparam logic [3:0] OP_JMP  = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd15;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

   localparam logic [2:0] SRCA_PC  = 3'd0;
   localparam logic [2:0] SRCA_ONE = 3'd1;
   localparam logic [2:0] SRCA_REG = 3'd2;
   localparam logic [2:0] SRCA_IMM = 3'd3;
   localparam logic [2:0] SRCA_MDR = 3'd4;

   localparam logic [1:0] SRCB_REG = 2'd0;
   localparam logic [1:0] SRCB_ONE = 2'd1;
   localparam logic [1:0] SRCB_IMM = 2'd2;

   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXEC_R    = 4'd3,
      S_R_WB      = 4'd4,
      S_EXEC_I    = 4'd5,
      S_I_WB      = 4'd6,
      S_MEM_ADDR  = 4'd7,
      S_MEM_READ  = 4'd8,
      S_MEM_WB    = 4'd9,
      S_MEM_WRITE = 4'd10,
      S_BRANCH    = 4'd11,
      S_JUMP      = 4'd12,
      S_HALT      = 4'd13
   } state_t;

   // States that stall on the memory handshake and therefore run the wait timer.
   function automatic logic isMemWaitState(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of a memory access and flags the cycle
// in which the stall limit would be exceeded (MEM_TIMEOUT = 0 never expires).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int WAIT_W      = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_waiting,
   output logic o_expired
);

   localparam int LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

   logic [WAIT_W-1:0] r_count;

   // The limit is hit in the stalled cycle that would bring the count to MEM_TIMEOUT.
   assign o_expired = (MEM_TIMEOUT != 0) && i_waiting && (r_count == WAIT_W'(LIMIT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_count <= '0;
      else if (i_waiting && !o_expired)
         r_count <= r_count + WAIT_W'(1);
      else
         r_count <= '0;
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: decodes the latched instruction and drives every
// datapath select and write strobe, with sticky illegal-op and memory-timeout flags.
module multicycle_control_unit
   import proc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int WAIT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic [2:0] funct,
   input  logic       zero,
   input  logic       negative,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic [3:0] alu_op,
   output logic [2:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       pc_src,
   output logic       keep_alu_out,
   output logic       halted,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state
);

   state_t r_state;
   logic   r_illegal;
   logic   r_timeout;
   state_t w_next;
   logic   w_waiting;
   logic   w_expired;
   logic   w_setIllegal;
   logic   w_setTimeout;

   assign w_waiting   = isMemWaitState(r_state) && !mem_ready;
   assign state       = r_state;
   assign illegal_op  = r_illegal;
   assign mem_timeout = r_timeout;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .WAIT_W      (WAIT_W)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .i_waiting (w_waiting),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_setIllegal)
            r_illegal <= 1'b1;
         if (w_setTimeout)
            r_timeout <= 1'b1;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_setIllegal = 1'b0;
      w_setTimeout = 1'b0;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      alu_op       = ALU_ADD;
      alu_src_a    = SRCA_PC;
      alu_src_b    = SRCB_REG;
      pc_src       = PCSRC_ALU;
      keep_alu_out = 1'b0;
      halted       = 1'b0;

      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_ONE;
            // A ready in the limit cycle still completes the fetch.
            if (mem_ready) begin
               pc_write = 1'b1;
               ir_write = 1'b1;
               w_next   = S_DECODE;
            end else if (w_expired) begin
               w_setTimeout = 1'b1;
               w_next       = S_HALT;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_R:                     w_next = S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI: w_next = S_EXEC_I;
               OP_LW, OP_SW:             w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE, OP_BLT:   w_next = S_BRANCH;
               OP_JMP:                   w_next = S_JUMP;
               OP_HALT:                  w_next = S_HALT;
               default: begin
                  w_setIllegal = 1'b1;
                  w_next       = S_HALT;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_REG;
            alu_op    = {1'b0, funct};
            w_next    = S_R_WB;
         end
         S_R_WB: begin
            reg_write    = 1'b1;
            reg_dst      = 1'b1;
            keep_alu_out = 1'b1;
            w_next       = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_ANDI: alu_op = ALU_AND;
               OP_ORI:  alu_op = ALU_OR;
               default: alu_op = ALU_ADD;
            endcase
            w_next = S_I_WB;
         end
         S_I_WB: begin
            reg_write    = 1'b1;
            keep_alu_out = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
            w_next    = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ, S_MEM_WRITE: begin
            mem_read     = (r_state == S_MEM_READ);
            mem_write    = (r_state == S_MEM_WRITE);
            keep_alu_out = 1'b1;
            if (mem_ready) begin
               w_next = (r_state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
            end else if (w_expired) begin
               w_setTimeout = 1'b1;
               w_next       = S_HALT;
            end
         end
         S_MEM_WB: begin
            reg_write    = 1'b1;
            mem_to_reg   = 1'b1;
            keep_alu_out = 1'b1;
            w_next       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a    = SRCA_REG;
            alu_src_b    = SRCB_REG;
            alu_op       = ALU_SUB;
            keep_alu_out = 1'b1;
            pc_src       = PCSRC_ALUOUT;
            pc_write     = ((opcode == OP_BEQ) && zero) ||
                           ((opcode == OP_BNE) && !zero) ||
                           ((opcode == OP_BLT) && negative);
            w_next       = S_FETCH;
         end
         S_JUMP: begin
            pc_src       = PCSRC_ALUOUT;
            pc_write     = 1'b1;
            keep_alu_out = 1'b1;
            w_next       = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: an instruction-level model expands each instruction
// into its expected per-cycle control trace, compared against the DUT.
module tb_multicycle_control_unit;

   localparam int TIMEOUT = 4;

   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_R_WB = 4;
   localparam int S_EXEC_I = 5, S_I_WB = 6, S_MEM_ADDR = 7, S_MEM_READ = 8, S_MEM_WB = 9;
   localparam int S_MEM_WRITE = 10, S_BRANCH = 11, S_JUMP = 12, S_HALT = 13;
   localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] opcode = '0;
   logic [2:0] funct = '0;
   logic       zero = 1'b0;
   logic       negative = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
   logic [3:0] alu_op;
   logic [2:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic       pc_src, keep_alu_out, halted, illegal_op, mem_timeout;
   logic [3:0] state;

   multicycle_control_unit #(
      .MEM_TIMEOUT (TIMEOUT),
      .WAIT_W      (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct        (funct),
      .zero         (zero),
      .negative     (negative),
      .mem_ready    (mem_ready),
      .pc_write     (pc_write),
      .ir_write     (ir_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .reg_write    (reg_write),
      .reg_dst      (reg_dst),
      .mem_to_reg   (mem_to_reg),
      .alu_op       (alu_op),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .pc_src       (pc_src),
      .keep_alu_out (keep_alu_out),
      .halted       (halted),
      .illegal_op   (illegal_op),
      .mem_timeout  (mem_timeout),
      .state        (state)
   );

   always #5 clk = ~clk;

   logic [24:0] actual;
   assign actual = {state, pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
                    mem_to_reg, alu_op, alu_src_a, alu_src_b, pc_src, keep_alu_out,
                    halted, illegal_op, mem_timeout};

   typedef struct {
      logic [24:0] exp;
      logic        rdy;
      logic [3:0]  op;
      logic [2:0]  fn;
      logic        z;
      logic        n;
   } step_t;

   step_t      q[$];
   logic       expIll = 1'b0;
   logic       expTo = 1'b0;
   logic [3:0] curOp;
   logic [2:0] curFn;
   logic       curZ, curN;
   int         passCount = 0;
   int         checkCount = 0;

   // Expected output word; sticky flags come from the model's own flag state.
   function automatic logic [24:0] mk(input int st, input int pcw, input int irw,
                                      input int mr, input int mw, input int rw,
                                      input int rd, input int m2r, input int aop,
                                      input int sa, input int sb, input int ps,
                                      input int kp);
      return {4'(st), 1'(pcw), 1'(irw), 1'(mr), 1'(mw), 1'(rw), 1'(rd), 1'(m2r),
              4'(aop), 3'(sa), 2'(sb), 1'(ps), 1'(kp), (st == S_HALT), expIll, expTo};
   endfunction

   task automatic pushStep(input logic [24:0] word, input logic rdy);
      step_t s;
      s.exp = word; s.rdy = rdy; s.op = curOp; s.fn = curFn; s.z = curZ; s.n = curN;
      q.push_back(s);
   endtask

   task automatic pushHalt();
      for (int i = 0; i < 3; i++)
         pushStep(mk(S_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'($urandom));
   endtask

   // A stalled memory phase: stays put for 'waits' cycles or gives up at the limit.
   task automatic pushMemWait(input logic [24:0] stallWord, input logic [24:0] doneWord,
                              input int waits, output bit timedOut);
      int n = (waits >= TIMEOUT) ? TIMEOUT : waits;
      for (int i = 0; i < n; i++)
         pushStep(stallWord, 1'b0);
      timedOut = (waits >= TIMEOUT);
      if (timedOut) begin
         expTo = 1'b1;
         pushHalt();
      end else begin
         pushStep(doneWord, 1'b1);
      end
   endtask

   // Reference model: expands one instruction into its expected cycle trace.
   task automatic plan(input logic [3:0] op, input logic [2:0] fn, input logic z,
                       input logic n, input int fWait, input int mWait);
      bit to;
      logic taken;
      curOp = op; curFn = fn; curZ = z; curN = n;
      pushMemWait(mk(S_FETCH, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 1, 0, 0),
                  mk(S_FETCH, 1, 1, 1, 0, 0, 0, 0, A_ADD, 0, 1, 0, 0), fWait, to);
      if (to) return;
      pushStep(mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, A_ADD, 0, 2, 0, 0), 1'($urandom));
      case (op)
         4'd0: begin
            pushStep(mk(S_EXEC_R, 0, 0, 0, 0, 0, 0, 0, int'(fn), 2, 0, 0, 0), 1'($urandom));
            pushStep(mk(S_R_WB, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1), 1'($urandom));
         end
         4'd1, 4'd2, 4'd3: begin
            pushStep(mk(S_EXEC_I, 0, 0, 0, 0, 0, 0, 0,
                        (op == 4'd1) ? A_ADD : (op == 4'd2) ? A_AND : A_OR, 2, 2, 0, 0),
                     1'($urandom));
            pushStep(mk(S_I_WB, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), 1'($urandom));
         end
         4'd4: begin
            pushStep(mk(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 0, A_ADD, 2, 2, 0, 0), 1'($urandom));
            pushMemWait(mk(S_MEM_READ, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1),
                        mk(S_MEM_READ, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1), mWait, to);
            if (!to)
               pushStep(mk(S_MEM_WB, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1), 1'($urandom));
         end
         4'd5: begin
            pushStep(mk(S_MEM_ADDR, 0, 0, 0, 0, 0, 0, 0, A_ADD, 2, 2, 0, 0), 1'($urandom));
            pushMemWait(mk(S_MEM_WRITE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1),
                        mk(S_MEM_WRITE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), mWait, to);
         end
         4'd6, 4'd7, 4'd8: begin
            taken = (op == 4'd6) ? z : (op == 4'd7) ? !z : n;
            pushStep(mk(S_BRANCH, int'(taken), 0, 0, 0, 0, 0, 0, A_SUB, 2, 0, 1, 1),
                     1'($urandom));
         end
         4'd9: pushStep(mk(S_JUMP, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'($urandom));
         4'd15: pushHalt();
         default: begin
            expIll = 1'b1;
            pushHalt();
         end
      endcase
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      expIll = 1'b0;
      expTo = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      checkCount++;
      if (actual !== mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
         $display("[TB] FAIL reset_initial: got %h expected %h", actual,
                  mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      else passCount++;
      applyReset();
      plan(4'd0, 3'd0, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ready = q[i].rdy; opcode = q[i].op; funct = q[i].fn;
         zero = q[i].z; negative = q[i].n;
         #1;
         checkCount++;
         if (actual !== q[i].exp)
            $display("[TB] FAIL reset_pre step %0d: got %h expected %h", i, actual, q[i].exp);
         else passCount++;
      end
      q.delete();
      #2 reset = 1'b1;
      #1;
      checkCount++;
      if (actual !== mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
         $display("[TB] FAIL reset_async: got %h expected 0", actual);
      else passCount++;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkCount++;
      if (actual !== mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
         $display("[TB] FAIL reset_idle: got %h expected 0", actual);
      else passCount++;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checkCount++;
      if (actual !== mk(S_FETCH, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 1, 0, 0))
         $display("[TB] FAIL reset_to_fetch: got %h expected %h", actual,
                  mk(S_FETCH, 0, 0, 1, 0, 0, 0, 0, A_ADD, 0, 1, 0, 0));
      else passCount++;
   endtask

   task automatic test_alu_ops();
      applyReset();
      plan(4'd0, 3'd0, 1'b0, 1'b0, 0, 0);
      for (int f = 1; f < 8; f++)
         plan(4'd0, 3'(f), 1'($urandom), 1'($urandom), $urandom_range(0, 3), 0);
      for (int op = 1; op < 4; op++)
         plan(4'(op), 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), 0);
      plan(4'd9, 3'd0, 1'b0, 1'b0, 0, 0);
      foreach (q[i]) begin
         @(negedge clk);
         mem_ready = q[i].rdy; opcode = q[i].op; funct = q[i].fn;
         zero = q[i].z; negative = q[i].n;
         #1;
         checkCount++;
         if (actual !== q[i].exp)
            $display("[TB] FAIL alu_ops step %0d: got %h expected %h", i, actual, q[i].exp);
         else passCount++;
      end
      q.delete();
   endtask

   task automatic test_mem();
      applyReset();
      plan(4'd4, 3'd0, 1'b0, 1'b0, 0, 3);
      plan(4'd5, 3'd0, 1'b0, 1'b0, 0, 0);
      plan(4'd4, 3'd0, 1'b1, 1'b1, 2, 0);
      plan(4'd5, 3'd0, 1'b1, 1'b0, 1, 3);
      plan(4'd9, 3'd0, 1'b0, 1'b0, 0, 0);
      foreach (q[i]) begin
         @(negedge clk);
         mem_ready = q[i].rdy; opcode = q[i].op; funct = q[i].fn;
         zero = q[i].z; negative = q[i].n;
         #1;
         checkCount++;
         if (actual !== q[i].exp)
            $display("[TB] FAIL mem step %0d: got %h expected %h", i, actual, q[i].exp);
         else passCount++;
      end
      q.delete();
   endtask

   task automatic test_branch();
      applyReset();
      plan(4'd6, 3'd0, 1'b1, 1'b0, 0, 0);
      plan(4'd6, 3'd0, 1'b0, 1'b1, 0, 0);
      plan(4'd7, 3'd0, 1'b0, 1'b0, 0, 0);
      plan(4'd7, 3'd0, 1'b1, 1'b1, 0, 0);
      plan(4'd8, 3'd0, 1'b1, 1'b1, 0, 0);
      plan(4'd8, 3'd0, 1'b1, 1'b0, 0, 0);
      plan(4'd9, 3'd0, 1'b0, 1'b0, 0, 0);
      foreach (q[i]) begin
         @(negedge clk);
         mem_ready = q[i].rdy; opcode = q[i].op; funct = q[i].fn;
         zero = q[i].z; negative = q[i].n;
         #1;
         checkCount++;
         if (actual !== q[i].exp)
            $display("[TB] FAIL branch step %0d: got %h expected %h", i, actual, q[i].exp);
         else passCount++;
      end
      q.delete();
   endtask

   task automatic test_timeout();
      for (int scen = 0; scen < 4; scen++) begin
         applyReset();
         case (scen)
            0: plan(4'd0, 3'd0, 1'b0, 1'b0, 10, 0);
            1: begin
               plan(4'd0, 3'd0, 1'b0, 1'b0, 3, 0);
               plan(4'd1, 3'd0, 1'b0, 1'b0, 0, 0);
            end
            2: plan(4'd4, 3'd0, 1'b0, 1'b0, 0, 4);
            default: plan(4'd5, 3'd0, 1'b0, 1'b0, 3, 9);
         endcase
         foreach (q[i]) begin
            @(negedge clk);
            mem_ready = q[i].rdy; opcode = q[i].op; funct = q[i].fn;
            zero = q[i].z; negative = q[i].n;
            #1;
            checkCount++;
            if (actual !== q[i].exp)
               $display("[TB] FAIL timeout%0d step %0d: got %h expected %h",
                        scen, i, actual, q[i].exp);
            else passCount++;
         end
         q.delete();
      end
   endtask

   task automatic test_illegal();
      for (int op = 10; op < 16; op++) begin
         applyReset();
         plan(4'(op), 3'd0, 1'b0, 1'b0, 0, 0);
         if (op == 15) begin
            applyReset();
            plan(4'd9, 3'd0, 1'b0, 1'b0, 0, 0);
         end
         foreach (q[i]) begin
            @(negedge clk);
            mem_ready = q[i].rdy; opcode = q[i].op; funct = q[i].fn;
            zero = q[i].z; negative = q[i].n;
            #1;
            checkCount++;
            if (actual !== q[i].exp)
               $display("[TB] FAIL illegal op%0d step %0d: got %h expected %h",
                        op, i, actual, q[i].exp);
            else passCount++;
         end
         q.delete();
      end
   endtask

   task automatic test_back_to_back();
      applyReset();
      for (int k = 0; k < 30; k++)
         plan(4'($urandom_range(0, 9)), 3'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3));
      plan(4'd15, 3'd0, 1'b0, 1'b0, 0, 0);
      foreach (q[i]) begin
         @(negedge clk);
         mem_ready = q[i].rdy; opcode = q[i].op; funct = q[i].fn;
         zero = q[i].z; negative = q[i].n;
         #1;
         checkCount++;
         if (actual !== q[i].exp)
            $display("[TB] FAIL back_to_back step %0d: got %h expected %h",
                     i, actual, q[i].exp);
         else passCount++;
      end
      q.delete();
   endtask

   initial begin
      #1;
      test_reset();
      test_alu_ops();
      test_mem();
      test_branch();
      test_timeout();
      test_illegal();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
